// File: rtl/vdp_cpu_port.sv
// CPU-side data/control port of the VDP: address/code latch, VRAM prefetch.
// Define VDP_GG_CRAM_EN for 12-bit two-byte palette writes.
module vdp_cpu_port (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic        cpu_sel,
  input  logic        cpu_wr,
  input  logic        cpu_port,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ready,
  input  logic [7:0]  status_in,
  output logic        status_rd,
  output logic [13:0] vram_a,
  output logic        vram_we,
  output logic [7:0]  vram_d,
  input  logic [7:0]  vram_q,
  output logic        cram_we,
  output logic [4:0]  cram_a,
  output logic [11:0] cram_d,
  output logic        reg_we,
  output logic [3:0]  reg_a,
  output logic [7:0]  reg_d
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE
  } state_t;

  state_t      state, state_nxt;
  logic [13:0] addr, addr_nxt;
  logic [13:0] addr_inc;
  logic [1:0]  code, code_nxt;
  logic        flag, flag_nxt;
  logic [7:0]  rbuf, rbuf_nxt;
  logic [7:0]  dout_nxt;

  logic        vram_we_nxt;
  logic [13:0] vram_a_nxt;
  logic [7:0]  vram_d_nxt;
  logic        cram_we_nxt;
  logic [4:0]  cram_a_nxt;
  logic [11:0] cram_d_nxt;
  logic        reg_we_nxt;
  logic [3:0]  reg_a_nxt;
  logic [7:0]  reg_d_nxt;
  logic        status_rd_nxt;

  logic        accept;
  logic        ctl_wr_lo;
  logic        ctl_wr_hi;
  logic        ctl_rd;
  logic        dat_wr;
  logic        dat_rd;

`ifdef VDP_GG_CRAM_EN
  logic [7:0]  latch, latch_nxt;
`endif

  assign cpu_ready = (state == IDLE);
  assign accept    = cpu_sel & cpu_ready;
  assign addr_inc  = addr + 14'd1;

  assign ctl_wr_lo = cpu_port & cpu_wr & ~flag;
  assign ctl_wr_hi = cpu_port & cpu_wr & flag;
  assign ctl_rd    = cpu_port & ~cpu_wr;
  assign dat_wr    = ~cpu_port & cpu_wr;
  assign dat_rd    = ~cpu_port & ~cpu_wr;

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    code_nxt      = code;
    flag_nxt      = flag;
    rbuf_nxt      = rbuf;
    dout_nxt      = cpu_dout;
    vram_we_nxt   = 1'b0;
    vram_a_nxt    = vram_a;
    vram_d_nxt    = vram_d;
    cram_we_nxt   = 1'b0;
    cram_a_nxt    = cram_a;
    cram_d_nxt    = cram_d;
    reg_we_nxt    = 1'b0;
    reg_a_nxt     = reg_a;
    reg_d_nxt     = reg_d;
    status_rd_nxt = 1'b0;
`ifdef VDP_GG_CRAM_EN
    latch_nxt     = latch;
`endif

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            ctl_wr_lo: begin
              addr_nxt[7:0] = cpu_din;
              flag_nxt      = 1'b1;
            end
            ctl_wr_hi: begin
              code_nxt = cpu_din[7:6];
              addr_nxt = {cpu_din[5:0], addr[7:0]};
              flag_nxt = 1'b0;
              if (cpu_din[7:6] == 2'd0) begin
                // prefetch uses the freshly assembled address
                state_nxt  = FETCH;
                vram_a_nxt = {cpu_din[5:0], addr[7:0]};
              end
              if (cpu_din[7:6] == 2'd2) begin
                reg_we_nxt = 1'b1;
                reg_a_nxt  = cpu_din[3:0];
                reg_d_nxt  = addr[7:0];
              end
            end
            ctl_rd: begin
              dout_nxt      = status_in;
              status_rd_nxt = 1'b1;
              flag_nxt      = 1'b0;
            end
            dat_wr: begin
              if (code != 2'd3) begin
                vram_we_nxt = 1'b1;
                vram_a_nxt  = addr;
                vram_d_nxt  = cpu_din;
              end else begin
`ifdef VDP_GG_CRAM_EN
                if (addr[0]) begin
                  cram_we_nxt = 1'b1;
                  cram_a_nxt  = addr[5:1];
                  cram_d_nxt  = {cpu_din[3:0], latch};
                end else begin
                  latch_nxt = cpu_din;
                end
`else
                cram_we_nxt = 1'b1;
                cram_a_nxt  = addr[4:0];
                cram_d_nxt  = {cpu_din[5:4], cpu_din[5:4],
                               cpu_din[3:2], cpu_din[3:2],
                               cpu_din[1:0], cpu_din[1:0]};
`endif
              end
              rbuf_nxt = cpu_din;
              addr_nxt = addr_inc;
              flag_nxt = 1'b0;
            end
            dat_rd: begin
              dout_nxt   = rbuf;
              flag_nxt   = 1'b0;
              state_nxt  = FETCH;
              vram_a_nxt = addr;
            end
            default: ;
          endcase
        end
      end
      FETCH: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        rbuf_nxt  = vram_q;
        addr_nxt  = addr_inc;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      code      <= '0;
      flag      <= 1'b0;
      rbuf      <= '0;
      cpu_dout  <= '0;
      vram_we   <= 1'b0;
      vram_a    <= '0;
      vram_d    <= '0;
      cram_we   <= 1'b0;
      cram_a    <= '0;
      cram_d    <= '0;
      reg_we    <= 1'b0;
      reg_a     <= '0;
      reg_d     <= '0;
      status_rd <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      code      <= code_nxt;
      flag      <= flag_nxt;
      rbuf      <= rbuf_nxt;
      cpu_dout  <= dout_nxt;
      vram_we   <= vram_we_nxt;
      vram_a    <= vram_a_nxt;
      vram_d    <= vram_d_nxt;
      cram_we   <= cram_we_nxt;
      cram_a    <= cram_a_nxt;
      cram_d    <= cram_d_nxt;
      reg_we    <= reg_we_nxt;
      reg_a     <= reg_a_nxt;
      reg_d     <= reg_d_nxt;
      status_rd <= status_rd_nxt;
    end
  end

`ifdef VDP_GG_CRAM_EN
  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      latch <= '0;
    end else begin
      latch <= latch_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Scoreboard bench for vdp_cpu_port: expected strobes/reads queued on drive,
// popped and compared by a negedge monitor.
module tb_vdp_cpu_port;

  logic        cpu_clk = 1'b0;
  logic        rst_n;
  logic        cpu_sel;
  logic        cpu_wr;
  logic        cpu_port;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ready;
  logic [7:0]  status_in;
  logic        status_rd;
  logic [13:0] vram_a;
  logic        vram_we;
  logic [7:0]  vram_d;
  logic [7:0]  vram_q;
  logic        cram_we;
  logic [4:0]  cram_a;
  logic [11:0] cram_d;
  logic        reg_we;
  logic [3:0]  reg_a;
  logic [7:0]  reg_d;

  always #5 cpu_clk = ~cpu_clk;

  vdp_cpu_port dut (
    .cpu_clk   (cpu_clk),
    .rst_n     (rst_n),
    .cpu_sel   (cpu_sel),
    .cpu_wr    (cpu_wr),
    .cpu_port  (cpu_port),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_ready (cpu_ready),
    .status_in (status_in),
    .status_rd (status_rd),
    .vram_a    (vram_a),
    .vram_we   (vram_we),
    .vram_d    (vram_d),
    .vram_q    (vram_q),
    .cram_we   (cram_we),
    .cram_a    (cram_a),
    .cram_d    (cram_d),
    .reg_we    (reg_we),
    .reg_a     (reg_a),
    .reg_d     (reg_d)
  );

  localparam int K_VRAM = 1;
  localparam int K_CRAM = 2;
  localparam int K_REG  = 3;
  localparam int K_STAT = 4;
  localparam int K_READ = 5;

  typedef struct {
    int          kind;
    logic [13:0] a;
    logic [11:0] d;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic acc_rd = 1'b0;
  logic [7:0] vram [0:16383];

  // synchronous VRAM: data valid one cycle after the address
  always @(posedge cpu_clk) begin
    if (vram_we) vram[vram_a] <= vram_d;
    vram_q <= vram[vram_a];
  end

  always @(posedge cpu_clk)
    acc_rd <= rst_n & cpu_sel & cpu_ready & ~cpu_wr;

  always @(negedge cpu_clk) begin : mon
    ev_t obs[$];
    ev_t e;
    obs = {};
    if (rst_n) begin
      if (vram_we)
        obs.push_back('{K_VRAM, vram_a, {4'h0, vram_d}});
      if (cram_we)
        obs.push_back('{K_CRAM, {9'h0, cram_a}, cram_d});
      if (reg_we)
        obs.push_back('{K_REG, {10'h0, reg_a}, {4'h0, reg_d}});
      if (status_rd)
        obs.push_back('{K_STAT, 14'h0, 12'h0});
      if (acc_rd)
        obs.push_back('{K_READ, 14'h0, {4'h0, cpu_dout}});
    end
    foreach (obs[i]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event kind=%0d a=%h d=%h (none required)",
                 obs[i].kind, obs[i].a, obs[i].d);
      end else begin
        e = exp_q.pop_front();
        if (obs[i].kind !== e.kind || obs[i].a !== e.a ||
            obs[i].d !== e.d) begin
          errors++;
          $display("FAIL event got kind=%0d a=%h d=%h want kind=%0d a=%h d=%h",
                   obs[i].kind, obs[i].a, obs[i].d, e.kind, e.a, e.d);
        end
      end
    end
  end

  function automatic void push(input int k, input logic [13:0] a,
                               input logic [11:0] d);
    exp_q.push_back('{k, a, d});
  endfunction

  task automatic access(input logic wr, input logic port,
                        input logic [7:0] din);
    int n = 0;
    cpu_sel  = 1'b1;
    cpu_wr   = wr;
    cpu_port = port;
    cpu_din  = din;
    while (!cpu_ready && n < 20) begin
      @(posedge cpu_clk); #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got ready=%b want 1", cpu_ready);
    end
    @(posedge cpu_clk); #1;
    cpu_sel = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) begin
      @(posedge cpu_clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d want 0", name, exp_q.size());
    end
    exp_q = {};
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    cpu_sel   = 1'b0;
    cpu_wr    = 1'b0;
    cpu_port  = 1'b0;
    cpu_din   = 8'h00;
    status_in = 8'h00;
    repeat (3) begin
      @(posedge cpu_clk); #1;
    end
    checks++;
    if ({vram_we, cram_we, reg_we, status_rd} !== 4'b0) begin
      errors++;
      $display("FAIL rst_strobes got %b want 0000",
               {vram_we, cram_we, reg_we, status_rd});
    end
    checks++;
    if ({vram_a, cram_a, reg_a} !== 23'h0) begin
      errors++;
      $display("FAIL rst_addrs got %h %h %h want 0", vram_a, cram_a, reg_a);
    end
    checks++;
    if ({vram_d, cram_d, reg_d} !== 28'h0) begin
      errors++;
      $display("FAIL rst_data got %h %h %h want 0", vram_d, cram_d, reg_d);
    end
    checks++;
    if (cpu_dout !== 8'h00) begin
      errors++;
      $display("FAIL rst_dout got %h want 00", cpu_dout);
    end
    rst_n = 1'b1;
    @(posedge cpu_clk); #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_ready got %b want 1", cpu_ready);
    end
  endtask

  task automatic test_vram_write();
    access(1'b1, 1'b1, 8'h34);
    access(1'b1, 1'b1, 8'h52);
    push(K_VRAM, 14'h1234, 12'h0AB);
    access(1'b1, 1'b0, 8'hAB);
    push(K_VRAM, 14'h1235, 12'h0CD);
    access(1'b1, 1'b0, 8'hCD);
    drain("vram_write");
  endtask

  task automatic test_reg_write();
    access(1'b1, 1'b1, 8'h0F);
    push(K_REG, 14'h0007, 12'h00F);
    access(1'b1, 1'b1, 8'h87);
    drain("reg_write");
  endtask

  task automatic test_prefetch();
    access(1'b1, 1'b1, 8'h00);
    access(1'b1, 1'b1, 8'h41);
    push(K_VRAM, 14'h0100, 12'h05A);
    access(1'b1, 1'b0, 8'h5A);
    push(K_VRAM, 14'h0101, 12'h0C3);
    access(1'b1, 1'b0, 8'hC3);
    access(1'b1, 1'b1, 8'h00);
    for (int r = 0; r < 3; r++) begin
      if (r == 0) access(1'b1, 1'b1, 8'h01);
      if (r == 1) begin
        push(K_READ, 14'h0, 12'h05A);
        access(1'b0, 1'b0, 8'h00);
      end
      if (r == 2) begin
        push(K_READ, 14'h0, 12'h0C3);
        access(1'b0, 1'b0, 8'h00);
      end
      checks++;
      if (cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy1_%0d got ready=%b want 0", r, cpu_ready);
      end
      @(posedge cpu_clk); #1;
      checks++;
      if (cpu_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy2_%0d got ready=%b want 0", r, cpu_ready);
      end
      @(posedge cpu_clk); #1;
      checks++;
      if (cpu_ready !== 1'b1) begin
        errors++;
        $display("FAIL busy_end_%0d got ready=%b want 1", r, cpu_ready);
      end
    end
    drain("prefetch");
  endtask

  task automatic test_cram();
    access(1'b1, 1'b1, 8'h00);
    access(1'b1, 1'b1, 8'hC0);
`ifdef VDP_GG_CRAM_EN
    push(K_CRAM, 14'h0000, 12'hE3F);
`else
    push(K_CRAM, 14'h0000, 12'hFFF);
    push(K_CRAM, 14'h0001, 12'h0FA);
`endif
    access(1'b1, 1'b0, 8'h3F);
    access(1'b1, 1'b0, 8'h0E);
    drain("cram");
  endtask

  task automatic test_wrap_flag();
    access(1'b1, 1'b1, 8'hFF);
    access(1'b1, 1'b1, 8'h7F);
    push(K_VRAM, 14'h3FFF, 12'h011);
    access(1'b1, 1'b0, 8'h11);
    push(K_VRAM, 14'h0000, 12'h022);
    access(1'b1, 1'b0, 8'h22);
    access(1'b1, 1'b1, 8'h12);
    status_in = 8'h9C;
    push(K_STAT, 14'h0, 12'h0);
    push(K_READ, 14'h0, 12'h09C);
    access(1'b0, 1'b1, 8'h00);
    status_in = 8'h00;
    access(1'b1, 1'b1, 8'h40);
    access(1'b1, 1'b1, 8'h41);
    push(K_VRAM, 14'h0140, 12'h077);
    access(1'b1, 1'b0, 8'h77);
    drain("wrap_flag");
  endtask

  task automatic test_back_to_back();
    push(K_VRAM, 14'h0141, 12'h001);
    push(K_VRAM, 14'h0142, 12'h002);
    push(K_VRAM, 14'h0143, 12'h003);
    for (int i = 1; i <= 3; i++) access(1'b1, 1'b0, 8'(i));
    checks++;
    if (cpu_dout !== 8'h9C) begin
      errors++;
      $display("FAIL dout_hold got %h want 9c", cpu_dout);
    end
    push(K_READ, 14'h0, 12'h003);
    access(1'b0, 1'b0, 8'h00);
    drain("back_to_back");
  endtask

  task automatic test_reset_in_fetch();
    access(1'b1, 1'b1, 8'h00);
    access(1'b1, 1'b1, 8'h00);
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL in_fetch got ready=%b want 0", cpu_ready);
    end
    rst_n = 1'b0;
    @(posedge cpu_clk); #1;
    checks++;
    if ({cpu_ready, vram_a, cpu_dout} !== {1'b1, 14'h0, 8'h0}) begin
      errors++;
      $display("FAIL fetch_rst got ready=%b a=%h dout=%h want 1 0 0",
               cpu_ready, vram_a, cpu_dout);
    end
    rst_n = 1'b1;
    @(posedge cpu_clk); #1;
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++;
      $display("FAIL fetch_rel got ready=%b want 1", cpu_ready);
    end
    push(K_READ, 14'h0, 12'h000);
    access(1'b0, 1'b0, 8'h00);
    push(K_READ, 14'h0, 12'h022);
    access(1'b0, 1'b0, 8'h00);
    drain("reset_in_fetch");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vram_write();
    test_reg_write();
    test_prefetch();
    test_cram();
    test_wrap_flag();
    test_back_to_back();
    test_reset_in_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
